// File: rtl/i2s_receiver_if.sv
// Stereo frame output port of the I2S receiver.
// Ports:
//   left_data  - left word of the presented frame
//   right_data - right word of the presented frame
//   out_valid  - frame available (driven by the receiver)
//   out_ready  - consumer accepts the frame (driven by the consumer)
interface i2s_receiver_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] left_data;
    logic [WORD_WIDTH-1:0] right_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output left_data,
        output right_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  left_data,
        input  right_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/i2s_receiver.sv
// Slave-mode I2S receiver, oversampled by clk. Deserialises one left and one
// right word per frame from externally driven bclk/ws/sd and presents each
// stereo frame on a valid/ready port.
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   bclk_in      - serial bit clock (asynchronous to clk)
//   ws_in        - word select, 0 = left, 1 = right (asynchronous)
//   sd_in        - serial data, MSB first (asynchronous)
//   frame        - output frame port (left_data/right_data/out_valid/out_ready)
//   overflow     - sticky: a completed frame was dropped
//   frame_err    - sticky: a channel slot was shorter than WORD_WIDTH
//   clear_flags  - single-cycle pulse clearing both sticky flags
//
// State | meaning
// IDLE  | waiting for the first ws 1->0 transition
// SHIFT | collecting bits of the current channel word
// HOLD  | word complete, discarding extra slot bits until ws changes
module i2s_receiver #(
    parameter int WORD_WIDTH     = 16,
    parameter bit LEFT_JUSTIFIED = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bclk_in,
    input  logic               ws_in,
    input  logic               sd_in,
    input  logic               clear_flags,
    i2s_receiver_if.master     frame,
    output logic               overflow,
    output logic               frame_err
);
    localparam int CW = $clog2(WORD_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                state;
    logic [2:0]            bclk_sync;   // [1:0] synchroniser, [2] previous value
    logic [1:0]            ws_sync;
    logic [1:0]            sd_sync;
    logic                  ws_prev;     // ws sampled at the previous bit edge
    logic                  chan;        // 0 = left, 1 = right
    logic [CW-1:0]         bit_cnt;
    logic [WORD_WIDTH-1:0] shift_reg;
    logic [WORD_WIDTH-1:0] left_hold;
    logic                  left_ok;     // left word of the current frame is held

    logic                  bit_edge;
    logic                  ws_trans;
    logic                  word_done;
    logic                  commit;
    logic [WORD_WIDTH-1:0] shifted;

    always_comb begin
        bit_edge  = bclk_sync[1] & ~bclk_sync[2];
        ws_trans  = bit_edge && (ws_sync[1] != ws_prev);
        shifted   = {shift_reg[WORD_WIDTH-2:0], sd_sync[1]};
        word_done = bit_edge && (state == SHIFT) && !ws_trans &&
                    (bit_cnt == CW'(WORD_WIDTH - 1));
        commit    = word_done && chan && left_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            bclk_sync        <= '0;
            ws_sync          <= '0;
            sd_sync          <= '0;
            ws_prev          <= 1'b0;
            chan             <= 1'b0;
            bit_cnt          <= '0;
            shift_reg        <= '0;
            left_hold        <= '0;
            left_ok          <= 1'b0;
            frame.left_data  <= '0;
            frame.right_data <= '0;
            frame.out_valid  <= 1'b0;
            overflow         <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], bclk_in};
            ws_sync   <= {ws_sync[0], ws_in};
            sd_sync   <= {sd_sync[0], sd_in};

            if (bit_edge) begin
                ws_prev <= ws_sync[1];
                case (state)
                    IDLE: begin
                        if (ws_prev && !ws_sync[1]) begin
                            state   <= SHIFT;
                            chan    <= 1'b0;
                            left_ok <= 1'b0;
                            // Left-justified: the edge that shows the ws change
                            // already carries the MSB.
                            if (LEFT_JUSTIFIED) begin
                                shift_reg <= shifted;
                                bit_cnt   <= CW'(1);
                            end else begin
                                bit_cnt   <= '0;
                            end
                        end
                    end
                    SHIFT: begin
                        if (ws_trans) begin
                            // Short slot: drop the partial word and the frame.
                            left_ok <= 1'b0;
                            chan    <= ws_sync[1];
                            if (LEFT_JUSTIFIED) begin
                                shift_reg <= shifted;
                                bit_cnt   <= CW'(1);
                            end else begin
                                bit_cnt   <= '0;
                            end
                        end else begin
                            shift_reg <= shifted;
                            bit_cnt   <= bit_cnt + CW'(1);
                            if (word_done) begin
                                state <= HOLD;
                                if (!chan) begin
                                    left_hold <= shifted;
                                    left_ok   <= 1'b1;
                                end else begin
                                    left_ok   <= 1'b0;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (ws_trans) begin
                            state <= SHIFT;
                            chan  <= ws_sync[1];
                            if (LEFT_JUSTIFIED) begin
                                shift_reg <= shifted;
                                bit_cnt   <= CW'(1);
                            end else begin
                                bit_cnt   <= '0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // A commit coinciding with a transfer replaces the accepted frame.
            if (commit && (!frame.out_valid || frame.out_ready)) begin
                frame.left_data  <= left_hold;
                frame.right_data <= shifted;
                frame.out_valid  <= 1'b1;
            end else if (frame.out_valid && frame.out_ready) begin
                frame.out_valid  <= 1'b0;
            end

            // Set conditions are evaluated after the clear so they win.
            if (clear_flags) begin
                overflow  <= 1'b0;
                frame_err <= 1'b0;
            end
            if (commit && frame.out_valid && !frame.out_ready)
                overflow <= 1'b1;
            if ((state == SHIFT) && ws_trans)
                frame_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: a Philips-mode and a left-justified
// instance share the same serial lines; expected words are hand-computed.
module tb_i2s_receiver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bclk_in = 1'b0;
    logic ws_in = 1'b1;
    logic sd_in = 1'b0;
    logic clear_flags = 1'b0;
    logic ovf_p, ferr_p, ovf_j, ferr_j;
    logic carry = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    int p_cnt = 0;
    int j_cnt = 0;
    logic [15:0] p_l = '0, p_r = '0, j_l = '0, j_r = '0;

    always #5 clk = ~clk;

    i2s_receiver_if #(.WORD_WIDTH(16)) bus_p ();
    i2s_receiver_if #(.WORD_WIDTH(16)) bus_j ();

    assign bus_j.out_ready = 1'b1;

    i2s_receiver #(.WORD_WIDTH(16), .LEFT_JUSTIFIED(1'b0)) dut_p (
        .clk(clk), .reset(reset), .bclk_in(bclk_in), .ws_in(ws_in), .sd_in(sd_in),
        .clear_flags(clear_flags), .frame(bus_p), .overflow(ovf_p), .frame_err(ferr_p)
    );

    i2s_receiver #(.WORD_WIDTH(16), .LEFT_JUSTIFIED(1'b1)) dut_j (
        .clk(clk), .reset(reset), .bclk_in(bclk_in), .ws_in(ws_in), .sd_in(sd_in),
        .clear_flags(clear_flags), .frame(bus_j), .overflow(ovf_j), .frame_err(ferr_j)
    );

    always @(negedge clk) begin
        if (bus_p.out_valid && bus_p.out_ready) begin
            p_l   <= bus_p.left_data;
            p_r   <= bus_p.right_data;
            p_cnt <= p_cnt + 1;
        end
        if (bus_j.out_valid && bus_j.out_ready) begin
            j_l   <= bus_j.left_data;
            j_r   <= bus_j.right_data;
            j_cnt <= j_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bit period: 8 clk low, 8 clk high; ws/sd change while bclk is low.
    task automatic send_bit(input logic w, input logic d);
        ws_in   = w;
        sd_in   = d;
        bclk_in = 1'b0;
        tick(8);
        bclk_in = 1'b1;
        tick(8);
    endtask

    // Words are MSB first, wbits long, zero-padded to the slot length.
    // Philips timing delays the stream by one bit; the first bit of the frame
    // is then the last stream bit of the previous frame.
    task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw,
                              input int lslot, input int rslot, input int wbits,
                              input bit philips, input int reset_at);
        logic stream [0:63];
        logic d;
        int   total;
        total = lslot + rslot;
        for (int p = 0; p < lslot; p++) begin
            if (p < wbits) stream[p] = lw[wbits-1-p];
            else           stream[p] = 1'b0;
        end
        for (int p = 0; p < rslot; p++) begin
            if (p < wbits) stream[lslot+p] = rw[wbits-1-p];
            else           stream[lslot+p] = 1'b0;
        end
        for (int k = 0; k < total; k++) begin
            if (k == reset_at) begin
                reset = 1'b1;
                tick(3);
                reset = 1'b0;
            end
            if (!philips)    d = stream[k];
            else if (k == 0) d = carry;
            else             d = stream[k-1];
            send_bit((k < lslot) ? 1'b0 : 1'b1, d);
        end
        carry = stream[total-1];
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        tick(1);
    endtask

    int base;

    initial begin
        bus_p.out_ready = 1'b1;
        tick(4);
        chk("rst_left", 32'(bus_p.left_data), 32'h0);
        chk("rst_right", 32'(bus_p.right_data), 32'h0);
        chk("rst_valid", 32'(bus_p.out_valid), 32'h0);
        chk("rst_ovf", 32'(ovf_p), 32'h0);
        chk("rst_ferr", 32'(ferr_p), 32'h0);
        reset = 1'b0;
        tick(4);
        repeat (4) send_bit(1'b1, 1'b0);

        // Basic Philips frame, consumer always ready.
        base = p_cnt;
        send_frame(32'hA5C3, 32'h1234, 32, 32, 16, 1'b1, -1);
        chk("t1_count", 32'(p_cnt - base), 32'd1);
        chk("t1_left", 32'(p_l), 32'hA5C3);
        chk("t1_right", 32'(p_r), 32'h1234);
        chk("t1_valid_low", 32'(bus_p.out_valid), 32'h0);
        chk("t1_ovf", 32'(ovf_p), 32'h0);
        chk("t1_ferr", 32'(ferr_p), 32'h0);

        // Back-pressure: second frame dropped, first frame held.
        bus_p.out_ready = 1'b0;
        base = p_cnt;
        send_frame(32'hA5C3, 32'h1234, 32, 32, 16, 1'b1, -1);
        chk("t2_valid", 32'(bus_p.out_valid), 32'h1);
        chk("t2_ovf_first", 32'(ovf_p), 32'h0);
        send_frame(32'h0F0F, 32'hF0F0, 32, 32, 16, 1'b1, -1);
        chk("t2_hold_left", 32'(bus_p.left_data), 32'hA5C3);
        chk("t2_hold_right", 32'(bus_p.right_data), 32'h1234);
        chk("t2_ovf", 32'(ovf_p), 32'h1);
        bus_p.out_ready = 1'b1;
        tick(2);
        chk("t2_xfer_count", 32'(p_cnt - base), 32'd1);
        chk("t2_xfer_left", 32'(p_l), 32'hA5C3);
        chk("t2_xfer_right", 32'(p_r), 32'h1234);
        chk("t2_valid_low", 32'(bus_p.out_valid), 32'h0);
        chk("t2_ovf_still", 32'(ovf_p), 32'h1);
        pulse_clear();
        chk("t2_ovf_clear", 32'(ovf_p), 32'h0);

        // Left slot cut short after 10 bits.
        base = p_cnt;
        send_frame(32'hFFFF, 32'h3C3C, 10, 32, 16, 1'b1, -1);
        chk("t3_ferr", 32'(ferr_p), 32'h1);
        chk("t3_no_frame", 32'(p_cnt - base), 32'd0);
        chk("t3_valid_low", 32'(bus_p.out_valid), 32'h0);
        send_frame(32'h0001, 32'h8000, 32, 32, 16, 1'b1, -1);
        chk("t3_next_count", 32'(p_cnt - base), 32'd1);
        chk("t3_next_left", 32'(p_l), 32'h0001);
        chk("t3_next_right", 32'(p_r), 32'h8000);
        pulse_clear();
        chk("t3_ferr_clear", 32'(ferr_p), 32'h0);

        // 24-bit slots: only the top 16 bits are kept, no error.
        base = p_cnt;
        send_frame(32'hDEADBE, 32'h123456, 24, 24, 24, 1'b1, -1);
        chk("t4_count", 32'(p_cnt - base), 32'd1);
        chk("t4_left", 32'(p_l), 32'hDEAD);
        chk("t4_right", 32'(p_r), 32'h1234);
        chk("t4_ferr", 32'(ferr_p), 32'h0);

        // Left-justified timing: exact for dut_j, one-bit shift for dut_p.
        base = j_cnt;
        send_frame(32'h8001, 32'h7FFE, 32, 32, 16, 1'b0, -1);
        chk("t5_lj_count", 32'(j_cnt - base), 32'd1);
        chk("t5_lj_left", 32'(j_l), 32'h8001);
        chk("t5_lj_right", 32'(j_r), 32'h7FFE);
        chk("t5_lj_ferr", 32'(ferr_j), 32'h0);
        chk("t5_ph_left", 32'(p_l), 32'h0002);
        chk("t5_ph_right", 32'(p_r), 32'hFFFC);
        send_frame(32'h8001, 32'h7FFE, 32, 32, 16, 1'b1, -1);
        chk("t5_lj_shift_left", 32'(j_l), 32'h4000);
        chk("t5_lj_shift_right", 32'(j_r), 32'h3FFF);
        chk("t5_ph_exact_left", 32'(p_l), 32'h8001);
        chk("t5_ph_exact_right", 32'(p_r), 32'h7FFE);

        // Reset part-way through the right slot.
        base = p_cnt;
        send_frame(32'h5555, 32'hAAAA, 32, 32, 16, 1'b1, 40);
        chk("t6_count", 32'(p_cnt - base), 32'd0);
        chk("t6_left", 32'(bus_p.left_data), 32'h0);
        chk("t6_right", 32'(bus_p.right_data), 32'h0);
        chk("t6_valid", 32'(bus_p.out_valid), 32'h0);
        chk("t6_ferr", 32'(ferr_p), 32'h0);
        send_frame(32'h1111, 32'h2222, 32, 32, 16, 1'b1, -1);
        chk("t6_next_count", 32'(p_cnt - base), 32'd1);
        chk("t6_next_left", 32'(p_l), 32'h1111);
        chk("t6_next_right", 32'(p_r), 32'h2222);
        chk("t6_next_ferr", 32'(ferr_p), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Slave-mode I2S receiver, oversampled by the system clock.
- Takes externally driven bclk/ws/sd, deserialises one left and one right word per frame, and presents each stereo frame on a valid/ready output port.
- Receive-side counterpart of the team's I2S transmit path; used for codec ADC capture and for loopback testing of the transmitter.

Parameters:
- WORD_WIDTH, 16, bits captured per channel (2..32).
- LEFT_JUSTIFIED, 0, 0 = Philips I2S (MSB one bclk after ws change); 1 = left-justified (MSB on the same bclk as the ws change).

Ports:
- clk  in  1  system clock, nominal 25 MHz.
- reset  in  1  asynchronous, active-high.
- bclk_in  in  1  serial bit clock, asynchronous to clk.
- ws_in  in  1  word select, asynchronous to clk; 0 = left, 1 = right.
- sd_in  in  1  serial data, asynchronous to clk.
- left_data  out  WORD_WIDTH  left word of the presented frame.
- right_data  out  WORD_WIDTH  right word of the presented frame.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame.
- overflow  out  1  sticky: a completed frame was dropped.
- frame_err  out  1  sticky: a channel slot was shorter than WORD_WIDTH.
- clear_flags  in  1  single-cycle pulse; clears overflow and frame_err.

Behaviour:
- Interface decision: reset is reset, asynchronous, active-high; clock is clk.
- Reset values: left_data=0, right_data=0, out_valid=0, overflow=0, frame_err=0, FSM=IDLE, bit counter=0, shift register=0.
- Input synchronisation:
  - bclk_in, ws_in and sd_in each pass through a 2-FF synchroniser.
  - A bclk rising edge is detected when the synchronised bclk was 0 on the previous cycle and is 1 now (single-cycle strobe "E").
  - ws and sd are sampled only on E.
- Input timing requirement: bclk high and low phases each >= 3 clk cycles. Behaviour is undefined below this.
- ws transition: the ws sampled at E differs from the ws sampled at the previous E.
- FSM states:
  - IDLE: ignore all bits until the first ws 1->0 transition, then go to SHIFT for the left channel. No error flags are raised in IDLE.
  - SHIFT: on each E, shift sd into the LSB of the shift register and increment the bit counter. When the counter reaches WORD_WIDTH, latch the word into that channel's holding register and go to HOLD.
  - HOLD: the slot is longer than WORD_WIDTH; extra bits are discarded. On a ws transition, go to SHIFT for the new channel with the counter cleared.
- MSB alignment:
  - LEFT_JUSTIFIED=0: the E that detects the ws transition carries the previous channel's trailing bit, which is discarded in HOLD. The next E captures the new MSB.
  - LEFT_JUSTIFIED=1: the same E that detects the transition captures the MSB.
- Short slot: a ws transition in SHIFT with counter < WORD_WIDTH:
  - sets frame_err;
  - discards the partial word and the whole current frame (left and right);
  - restarts SHIFT for the new channel.
- Frame commit: when the right word completes with a valid left word held from the same frame:
  - If out_valid=0: load left_data/right_data and assert out_valid on the cycle after that E.
  - If out_valid=1 and out_ready=0: drop the new frame and set overflow. The presented data stays unchanged.
  - If out_valid=1 and out_ready=1 in the same cycle as the commit: accept the old frame and load the new one; out_valid stays 1. No overflow.
- Handshake:
  - Transfer occurs when out_valid and out_ready are both 1; out_valid deasserts the next cycle unless a commit coincides.
  - left_data/right_data are stable while out_valid=1.
- Flags: clear_flags clears both flags. If a set condition occurs in the same cycle, the set wins.
- Reset mid-frame: all state returns to reset values immediately; reception resumes only after the next ws 1->0 transition.

Test Plan:
- Philips mode, WORD_WIDTH=16, bclk period 16 clk, left=16'hA5C3, right=16'h1234, out_ready=1 -> one out_valid pulse with left_data=A5C3, right_data=1234; overflow=0, frame_err=0.
- Same stimulus with out_ready=0 for two consecutive frames (A5C3/1234 then 0F0F/F0F0) -> data held at A5C3/1234, overflow=1. Raising out_ready then transfers A5C3/1234. A clear_flags pulse then gives overflow=0.
- Left slot truncated after 10 bits (ws toggles early) -> frame_err=1 and no out_valid for that frame. The next well-formed frame 0001/8000 is delivered correctly.
- 24-bit slots with WORD_WIDTH=16, left slot bits 24'hDEADBE (MSB first) -> left_data=DEAD; extra bits are ignored, no error.
- LEFT_JUSTIFIED=1, left=16'h8001, right=16'h7FFE -> out_valid with exactly those values. Driving Philips-timed data in this mode yields the words shifted by one bit.
- Reset asserted midway through the right slot, then released -> outputs at reset values; bits before the next ws 1->0 are ignored; the following frame 1111/2222 is delivered.
